// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Instruction-side memory initiator. It requests the word at pc, waits for
// the memory acknowledge, then holds the instruction on inst until the
// datapath retires it. On retire the pc advances by one, or jumps inside
// the current 4K page.
//
// Optional feature macro: NUM_INST_EN
//   defined   -> num_inst counts retired instructions (wraps at all-ones)
//   undefined -> counter removed, num_inst tied to zero
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   readM        registered memory read request
//   address      read address, equals pc while readM is high
//   data         memory read data, valid with inputReady
//   inputReady   memory acknowledge for the outstanding read
//   inst         latched instruction for the decoder
//   inst_valid   inst holds an instruction not yet retired
//   pc           address of the instruction in inst
//   retire       datapath finished the current instruction
//   jump         qualifies retire: load jump_target into pc[11:0]
//   jump_target  low 12 bits of the jump destination
//   num_inst     retired instruction count
module inst_fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 readM,
    output logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    output logic [WORD_SIZE-1:0] inst,
    output logic                 inst_valid,
    output logic [WORD_SIZE-1:0] pc,
    input  logic                 retire,
    input  logic                 jump,
    input  logic [11:0]          jump_target,
    output logic [WORD_SIZE-1:0] num_inst
);

    typedef enum logic [1:0] {
        RST   = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [WORD_SIZE-1:0] pc_next;

    // Jumps stay inside the current 4K page: only the low 12 bits are replaced.
    always_comb begin
        pc_next = pc + 1'b1;
        if (jump) begin
            pc_next = {pc[WORD_SIZE-1:12], jump_target};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RST:     state_d = FETCH;
            FETCH:   if (inputReady) state_d = EXEC;
            EXEC:    if (retire)     state_d = FETCH;
            default: state_d = RST;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are registered and updated on the transitions, so readM is
    // already high during the first FETCH cycle and the new pc/address show
    // up together with the re-asserted request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readM      <= 1'b0;
            address    <= '0;
            inst       <= '0;
            inst_valid <= 1'b0;
            pc         <= RESET_PC;
        end else begin
            case (state_q)
                RST: begin
                    readM   <= 1'b1;
                    address <= pc;
                end
                FETCH: begin
                    if (inputReady) begin
                        inst       <= data;
                        readM      <= 1'b0;
                        inst_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        inst_valid <= 1'b0;
                        readM      <= 1'b1;
                        pc         <= pc_next;
                        address    <= pc_next;
                    end
                end
                default: begin
                    readM <= 1'b0;
                end
            endcase
        end
    end

`ifdef NUM_INST_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_inst <= '0;
        end else if (state_q == EXEC && retire) begin
            num_inst <= num_inst + 1'b1;
        end
    end
`else
    assign num_inst = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam logic [15:0] RPC = 16'hFFFE;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        readM;
    logic [15:0] address;
    logic [15:0] data;
    logic        inputReady = 1'b0;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] pc;
    logic        retire = 1'b0;
    logic        jump = 1'b0;
    logic [11:0] jump_target = 12'h000;
    logic [15:0] num_inst;

    int checks = 0;
    int failures = 0;

    inst_fetch_unit #(
        .WORD_SIZE(16),
        .RESET_PC (RPC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .readM      (readM),
        .address    (address),
        .data       (data),
        .inputReady (inputReady),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .retire     (retire),
        .jump       (jump),
        .jump_target(jump_target),
        .num_inst   (num_inst)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] mem(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'd40503;
        return p ^ 16'h1F2E;
    endfunction

    always_comb data = mem(address);

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a fetch is outstanding or an instruction is held.
    bit          m_on = 0;
    bit          m_wait = 0;
    bit          m_val = 0;
    logic [15:0] m_pc = RPC;
    logic [15:0] m_inst = '0;
    logic [15:0] m_cnt = '0;

    function automatic logic [15:0] exp_cnt();
`ifdef NUM_INST_EN
        return m_cnt;
`else
        return 16'h0000;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_on = 0; m_wait = 0; m_val = 0;
                m_pc = RPC; m_inst = '0; m_cnt = '0;
            end else if (!m_on) begin
                m_on = 1; m_wait = 1;
            end else if (m_wait) begin
                if (inputReady) begin
                    m_inst = mem(m_pc);
                    m_wait = 0;
                    m_val  = 1;
                end
            end else if (retire) begin
                m_cnt = m_cnt + 16'd1;
                m_pc  = jump ? {m_pc[15:12], jump_target} : m_pc + 16'd1;
                m_val = 0;
                m_wait = 1;
            end
            #1;
            chk("readM", {15'd0, readM}, {15'd0, m_wait});
            chk("inst_valid", {15'd0, inst_valid}, {15'd0, m_val});
            chk("pc", pc, m_pc);
            chk("inst", inst, m_inst);
            chk("num_inst", num_inst, exp_cnt());
            if (m_wait) chk("address", address, m_pc);
            else if (!m_on) chk("address_rst", address, 16'h0000);
        end
    end

    // Inputs are applied at edge+2 and consumed by the following edge.
    task automatic cyc(input logic r, input logic rt, input logic j, input logic [11:0] t);
        inputReady  = r;
        retire      = rt;
        jump        = j;
        jump_target = t;
        @(posedge clk);
        #2;
    endtask

    task automatic run_inst(input logic j, input logic [11:0] t, input int unsigned waits);
        for (int unsigned w = 0; w < waits; w++) cyc(1'b0, 1'b0, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b0, 1'b1, j, t);
    endtask

    task automatic reset_pulse();
        #1 reset_n = 1'b0;
        #1;
        chk("async_readM", {15'd0, readM}, 16'h0000);
        chk("async_valid", {15'd0, inst_valid}, 16'h0000);
        chk("async_pc", pc, RPC);
        chk("async_inst", inst, 16'h0000);
        chk("async_addr", address, 16'h0000);
        chk("async_num", num_inst, 16'h0000);
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] held;
        logic [31:0] r;

        #1 reset_n = 1'b0;
        #1;
        chk("rst_pc", pc, RPC);
        chk("rst_readM", {15'd0, readM}, 16'h0000);
        @(posedge clk);
        #2 reset_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        chk("first_fetch_readM", {15'd0, readM}, 16'h0001);
        chk("first_fetch_addr", address, RPC);

        // Sequential fetch with immediate ack and retire, wrapping FFFF -> 0000.
        for (int i = 0; i < 4; i++) begin
            run_inst(1'b0, 12'h000, 0);
            chk("seq_inst", inst, mem(RPC + 16'(i)));
            chk("seq_pc", pc, RPC + 16'(i + 1));
            if (i == 1) chk("wrap_addr", address, 16'h0000);
        end
`ifdef NUM_INST_EN
        chk("num_after4", num_inst, 16'h0004);
`else
        chk("num_after4", num_inst, 16'h0000);
`endif

        // Slow memory: three cycles without ack, request and address held.
        held = pc;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 12'h000);
            chk("slow_readM", {15'd0, readM}, 16'h0001);
            chk("slow_addr", address, held);
        end
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        chk("slow_inst", inst, mem(held));
        cyc(1'b0, 1'b1, 1'b0, 12'h000);

        // Walk to 0x1234 and take the documented jump.
        run_inst(1'b1, 12'hFFF, 0);
        chk("jump_fff", pc, 16'h0FFF);
        run_inst(1'b0, 12'h000, 1);
        chk("step_1000", pc, 16'h1000);
        run_inst(1'b1, 12'h234, 0);
        chk("jump_1234", pc, 16'h1234);
        run_inst(1'b1, 12'h0AB, 2);
        chk("jump_10ab", address, 16'h10AB);

        // Stray ack in EXEC, stray retire/jump in FETCH.
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        held = inst;
        cyc(1'b1, 1'b0, 1'b0, 12'h000);
        chk("stray_ack_inst", inst, held);
        chk("stray_ack_valid", {15'd0, inst_valid}, 16'h0001);
        cyc(1'b0, 1'b1, 1'b0, 12'h000);
        held = pc;
        cyc(1'b0, 1'b1, 1'b1, 12'h555);
        chk("stray_ret_pc", pc, held);
        chk("stray_ret_readM", {15'd0, readM}, 16'h0001);
        run_inst(1'b0, 12'h000, 0);

        // Reset while a fetch is outstanding.
        cyc(1'b0, 1'b0, 1'b0, 12'h000);
        reset_pulse();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            r = $urandom;
            if (r[31:25] == 7'd0) begin
                reset_pulse();
            end else begin
                cyc(r[2:0] != 3'd0, r[5:3] > 3'd2, r[6], r[18:7]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
